// File: rtl/tt_pkg.sv
`default_nettype none
// ============================================================================
// Module     : tt_pkg
// Description: Shared types and constants for the truth-table sweeper/checker.
//              NUM_INPUTS - number of inputs of the function under test
//              TT_BITS    - truth-table width (2**NUM_INPUTS)
//              tt_t       - one full truth table
//              idx_t      - one input assignment / truth-table index
//              state_t    - sweeper FSM states
// Revision   : 1.0 - initial release
// ============================================================================
package tt_pkg;

  localparam int NUM_INPUTS = 7;
  localparam int TT_BITS    = 2 ** NUM_INPUTS;

  typedef logic [TT_BITS-1:0]    tt_t;
  typedef logic [NUM_INPUTS-1:0] idx_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Index of the final input assignment of a sweep.
  localparam idx_t IDX_LAST = idx_t'(TT_BITS - 1);

endpackage
`default_nettype wire

// File: rtl/tt_capture_delay.sv
`default_nettype none
// ============================================================================
// Module     : tt_capture_delay
// Description: Aligns the sweep index with the response of a pipelined
//              function block. PIPE_LAT stages of {valid, idx}; with
//              PIPE_LAT = 0 it is a plain pass-through.
// Ports      : clk      in  clock, rising edge
//              rst      in  asynchronous active-high reset
//              valid_i  in  an input assignment is being driven this cycle
//              idx_i    in  the assignment being driven
//              valid_o  out delayed valid (f_in belongs to idx_o)
//              idx_o    out delayed assignment
// Revision   : 1.0 - initial release
// ============================================================================
module tt_capture_delay
  import tt_pkg::*;
#(
  parameter int PIPE_LAT = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic valid_i,
  input  idx_t idx_i,
  output logic valid_o,
  output idx_t idx_o
);

  generate
    if (PIPE_LAT == 0) begin : g_pass
      // Clock and reset have no load in the pass-through build.
      logic w_unused_clk_rst;
      assign w_unused_clk_rst = clk ^ rst;

      assign valid_o = valid_i;
      assign idx_o   = idx_i;
    end else begin : g_pipe
      logic [PIPE_LAT-1:0] vld_q;
      idx_t                idx_q [PIPE_LAT];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld_q <= '0;
          for (int s = 0; s < PIPE_LAT; s++) begin
            idx_q[s] <= '0;
          end
        end else begin
          vld_q[0] <= valid_i;
          idx_q[0] <= idx_i;
          for (int s = 1; s < PIPE_LAT; s++) begin
            vld_q[s] <= vld_q[s-1];
            idx_q[s] <= idx_q[s-1];
          end
        end
      end

      assign valid_o = vld_q[PIPE_LAT-1];
      assign idx_o   = idx_q[PIPE_LAT-1];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/tt_sweep_checker.sv
`default_nettype none
// ============================================================================
// Module     : tt_sweep_checker
// Description: Exhaustive truth-table sweeper/checker for a 7-input,
//              single-output function block. Drives all 128 input
//              assignments in ascending order, captures the response into a
//              128-bit truth table and compares it with a latched expected
//              signature.
// Ports      : clk       in  clock, rising edge
//              rst       in  asynchronous active-high reset
//              start     in  begin a sweep (sampled only in IDLE)
//              expected  in  expected truth table, latched on start
//              x         out function inputs, x[0]->x0 ... x[6]->x6
//              f_in      in  function output
//              busy      out high from start acceptance until done
//              done      out one-cycle pulse, tt/match valid from here
//              match     out tt equals the latched expected table
//              tt        out captured truth table, tt[i] = f(x=i)
// Option     : `define TT_FIRST_MISMATCH_EN adds
//              first_mismatch out lowest index where tt differs from expected
//              any_mismatch   out at least one index differs
// Parameters : PIPE_LAT - cycles from x change to f_in valid
// Revision   : 1.0 - initial release
// ============================================================================
module tt_sweep_checker
  import tt_pkg::*;
#(
  parameter int PIPE_LAT = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  tt_t  expected,
  output idx_t x,
  input  logic f_in,
  output logic busy,
  output logic done,
  output logic match,
`ifdef TT_FIRST_MISMATCH_EN
  output idx_t first_mismatch,
  output logic any_mismatch,
`endif
  output tt_t  tt
);

  // Drain counter runs 0..PIPE_LAT-1; keep it at least one bit wide.
  localparam int DRAIN_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'((PIPE_LAT > 0) ? PIPE_LAT - 1 : 0);

  state_t              state_q;
  idx_t                idx_q;
  tt_t                 exp_q;
  tt_t                 tt_q;
  tt_t                 tt_d;
  logic                busy_q;
  logic                done_q;
  logic                match_q;
  logic [DRAIN_W-1:0]  drain_cnt_q;

  logic                w_start_acc;
  logic                w_cap_vld;
  idx_t                w_cap_idx;
  logic                w_match;

  assign w_start_acc = (state_q == IDLE) && start;

  tt_capture_delay #(
    .PIPE_LAT (PIPE_LAT)
  ) u_capture_delay (
    .clk     (clk),
    .rst     (rst),
    .valid_i (state_q == SWEEP),
    .idx_i   (idx_q),
    .valid_o (w_cap_vld),
    .idx_o   (w_cap_idx)
  );

  always_comb begin
    tt_d = tt_q;
    if (w_cap_vld) begin
      tt_d[w_cap_idx] = f_in;
    end
  end

  // The final capture lands on the same edge that enters DONE, so match is
  // taken from the next-state table rather than the registered one.
  assign w_match = (tt_d == exp_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      exp_q       <= '0;
      tt_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      match_q     <= 1'b0;
      drain_cnt_q <= '0;
    end else begin
      done_q <= 1'b0;
      tt_q   <= tt_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= SWEEP;
            exp_q   <= expected;
            tt_q    <= '0;
            busy_q  <= 1'b1;
            match_q <= 1'b0;
            idx_q   <= '0;
          end
        end
        SWEEP: begin
          if (idx_q == IDX_LAST) begin
            // idx holds at the last assignment; x stays 127 until IDLE.
            if (PIPE_LAT > 0) begin
              state_q     <= DRAIN;
              drain_cnt_q <= '0;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              match_q <= w_match;
            end
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DRAIN: begin
          if (drain_cnt_q == DRAIN_LAST) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            match_q <= w_match;
          end else begin
            drain_cnt_q <= drain_cnt_q + 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          idx_q   <= '0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef TT_FIRST_MISMATCH_EN
  idx_t first_q;
  logic any_q;

  // Captures arrive in ascending index order, so the first differing capture
  // is the lowest differing index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_q <= '0;
      any_q   <= 1'b0;
    end else if (w_start_acc) begin
      first_q <= '0;
      any_q   <= 1'b0;
    end else if (w_cap_vld && !any_q && (f_in != exp_q[w_cap_idx])) begin
      first_q <= w_cap_idx;
      any_q   <= 1'b1;
    end
  end

  assign first_mismatch = first_q;
  assign any_mismatch   = any_q;
`endif

  assign x     = idx_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign match = match_q;
  assign tt    = tt_q;

endmodule
`default_nettype wire

// File: tb/tb_tt_sweep_checker.sv
`default_nettype none
// ============================================================================
// Module     : tb_tt_sweep_checker
// Description: Self-checking bench for tt_sweep_checker. Two checkers are
//              instantiated: one facing a combinational function block
//              (PIPE_LAT = 0) and one facing a two-cycle registered block
//              (PIPE_LAT = 2). Each function block is a lookup into a
//              bench-owned truth table, so the expected captured table is
//              that table itself.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_tt_sweep_checker;
  import tt_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic start0, start2;
  tt_t  exp0, exp2;
  tt_t  fn0, fn2;
  idx_t x0w, x2w;
  logic f0, f2;
  logic busy0, busy2, done0, done2, match0, match2;
  tt_t  tt0, tt2;
`ifdef TT_FIRST_MISMATCH_EN
  idx_t fm0, fm2;
  logic am0, am2;
`endif

  // Function blocks: combinational for checker 0, two register stages for 2.
  idx_t x2_d1 = '0;
  idx_t x2_d2 = '0;
  always @(posedge clk) begin
    x2_d1 <= x2w;
    x2_d2 <= x2_d1;
  end
  assign f0 = fn0[x0w];
  assign f2 = fn2[x2_d2];

  tt_sweep_checker #(.PIPE_LAT(0)) u_dut0 (
    .clk            (clk),
    .rst            (rst),
    .start          (start0),
    .expected       (exp0),
    .x              (x0w),
    .f_in           (f0),
    .busy           (busy0),
    .done           (done0),
    .match          (match0),
`ifdef TT_FIRST_MISMATCH_EN
    .first_mismatch (fm0),
    .any_mismatch   (am0),
`endif
    .tt             (tt0)
  );

  tt_sweep_checker #(.PIPE_LAT(2)) u_dut2 (
    .clk            (clk),
    .rst            (rst),
    .start          (start2),
    .expected       (exp2),
    .x              (x2w),
    .f_in           (f2),
    .busy           (busy2),
    .done           (done2),
    .match          (match2),
`ifdef TT_FIRST_MISMATCH_EN
    .first_mismatch (fm2),
    .any_mismatch   (am2),
`endif
    .tt             (tt2)
  );

  // Selected checker (0 or 2) for the shared tasks.
  int   cur = 0;
  idx_t x_s;
  logic busy_s, done_s, match_s;
  tt_t  tt_s;
  assign x_s     = (cur == 2) ? x2w    : x0w;
  assign busy_s  = (cur == 2) ? busy2  : busy0;
  assign done_s  = (cur == 2) ? done2  : done0;
  assign match_s = (cur == 2) ? match2 : match0;
  assign tt_s    = (cur == 2) ? tt2    : tt0;
`ifdef TT_FIRST_MISMATCH_EN
  idx_t fm_s;
  logic am_s;
  assign fm_s = (cur == 2) ? fm2 : fm0;
  assign am_s = (cur == 2) ? am2 : am0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input tt_t obs, input tt_t expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic tt_t bit_pattern(input int b);
    tt_t t;
    for (int i = 0; i < TT_BITS; i++) t[i] = ((i >> b) & 1) == 1;
    return t;
  endfunction

  function automatic int first_diff(input tt_t a, input tt_t b);
    for (int i = 0; i < TT_BITS; i++) if (a[i] != b[i]) return i;
    return 0;
  endfunction

  function automatic tt_t rand_tt();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic set_start(input logic v);
    if (cur == 2) start2 = v; else start0 = v;
  endtask

  task automatic set_exp(input tt_t v);
    if (cur == 2) exp2 = v; else exp0 = v;
  endtask

  task automatic set_fn(input tt_t v);
    if (cur == 2) fn2 = v; else fn0 = v;
  endtask

  // One full sweep on the selected checker. disturb: re-pulse start in c40
  // and change expected in c60. hold: keep start high throughout.
  task automatic sweep(input string tag, input tt_t fn, input tt_t ev,
                       input bit disturb, input bit hold);
    int lat;
    int done_cyc;
    bit x_ok;
    bit busy_ok;
    bit seen;
    lat = (cur == 2) ? 2 : 0;
    set_fn(fn);
    @(posedge clk); #1;
    set_start(1'b1);
    set_exp(ev);
    @(posedge clk); #1;              // edge c0 has accepted start
    if (!hold) set_start(1'b0);
    done_cyc = 0;
    x_ok     = 1'b1;
    busy_ok  = 1'b1;
    for (int k = 1; k <= 400 && done_cyc == 0; k++) begin
      @(negedge clk);
      if (k <= 128 && int'(x_s) != k - 1) x_ok = 1'b0;
      if (k > 128 && int'(x_s) != 127) x_ok = 1'b0;
      if (k <= 128 + lat && busy_s !== 1'b1) busy_ok = 1'b0;
      if (done_s === 1'b1) done_cyc = k;
      if (disturb && k == 40) set_start(1'b1);
      if (disturb && k == 41) set_start(1'b0);
      if (disturb && k == 60) set_exp(~ev);
    end
    check({tag, " done_cycle"}, tt_t'(done_cyc), tt_t'(129 + lat));
    check({tag, " x_sequence"}, tt_t'(x_ok), 1);
    check({tag, " busy_during"}, tt_t'(busy_ok), 1);
    check({tag, " busy_at_done"}, tt_t'(busy_s), 0);
    check({tag, " tt"}, tt_s, fn);
    check({tag, " match"}, tt_t'(match_s), tt_t'(fn == ev));
`ifdef TT_FIRST_MISMATCH_EN
    check({tag, " any_mismatch"}, tt_t'(am_s), tt_t'(fn != ev));
    check({tag, " first_mismatch"}, tt_t'(fm_s), tt_t'((fn != ev) ? first_diff(fn, ev) : 0));
`endif
    if (hold) begin
      @(negedge clk);
      check({tag, " idle_busy"}, tt_t'(busy_s), 0);
      check({tag, " idle_x"}, tt_t'(x_s), 0);
      @(negedge clk);
      check({tag, " relaunch_busy"}, tt_t'(busy_s), 1);
      set_start(1'b0);
      seen = 1'b0;
      for (int k = 0; k < 300 && !seen; k++) begin
        @(negedge clk);
        if (done_s === 1'b1) seen = 1'b1;
      end
      check({tag, " relaunch_done"}, tt_t'(seen), 1);
      check({tag, " relaunch_tt"}, tt_s, fn);
    end else begin
      @(negedge clk);
      check({tag, " done_pulse"}, tt_t'(done_s), 0);
      check({tag, " match_held"}, tt_t'(match_s), tt_t'(fn == ev));
      check({tag, " tt_held"}, tt_s, fn);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, " x"}, tt_t'(x_s), 0);
    check({tag, " busy"}, tt_t'(busy_s), 0);
    check({tag, " done"}, tt_t'(done_s), 0);
    check({tag, " match"}, tt_t'(match_s), 0);
    check({tag, " tt"}, tt_s, 0);
`ifdef TT_FIRST_MISMATCH_EN
    check({tag, " first_mismatch"}, tt_t'(fm_s), 0);
    check({tag, " any_mismatch"}, tt_t'(am_s), 0);
`endif
  endtask

  initial begin
    tt_t one;
    tt_t fn;
    tt_t ev;
    one    = 1;
    rst    = 1'b1;
    start0 = 1'b0;
    start2 = 1'b0;
    exp0   = '0;
    exp2   = '0;
    fn0    = '0;
    fn2    = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state of both checkers.
    @(negedge clk);
    cur = 0; #0 check_zero("reset0");
    cur = 2; #0 check_zero("reset2");

    // Constant-0 function, expected all zero.
    cur = 0;
    sweep("const0", '0, '0, 0, 0);

    // f = x0.
    sweep("x0", bit_pattern(0), 128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA, 0, 0);

    // f = x6 through a two-cycle registered block.
    cur = 2;
    sweep("x6_lat2", bit_pattern(6), 128'hFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0000, 0, 0);

    // f = x0 with a single flipped entry at x = 37.
    cur = 0;
    sweep("x0_flip37", bit_pattern(0) ^ (one << 37), 128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA, 0, 0);

    // Reset while x = 50, then a clean sweep.
    fn = rand_tt();
    fn0 = fn;
    @(posedge clk); #1;
    start0 = 1'b1;
    exp0   = fn;
    @(posedge clk); #1;
    start0 = 1'b0;
    for (int k = 1; k <= 51; k++) @(negedge clk);
    check("midrst x_before", tt_t'(x_s), 50);
    rst = 1'b1;
    #1 check_zero("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_zero("midrst_after");
    fn = rand_tt();
    sweep("post_rst", fn, fn, 0, 0);

    // start re-pulse and expected change mid-sweep have no effect.
    fn = rand_tt();
    sweep("disturb0", fn, fn, 1, 0);
    cur = 2;
    fn = rand_tt();
    ev = fn ^ (one << $urandom_range(127));
    sweep("disturb2", fn, ev, 1, 0);

    // start held high: ignored in DONE, relaunches from IDLE.
    cur = 0;
    fn = rand_tt();
    sweep("hold", fn, fn, 0, 1);

    // Randomized functions and expected tables on both checkers.
    for (int r = 0; r < 6; r++) begin
      cur = (r % 2 == 0) ? 0 : 2;
      fn = rand_tt();
      case ($urandom_range(2))
        0:       ev = fn;
        1:       ev = fn ^ (one << $urandom_range(127)) ^ (one << $urandom_range(127));
        default: ev = rand_tt();
      endcase
      sweep("random", fn, ev, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
